comparador_multi: RTL and testbench

// - Parametrised successor of the single-channel registered equality comparator.
// - Compares one counter value A against CHANNELS independent thresholds, each with its own mode.
// - Adds a per-channel persistence (hold) filter, a rising-edge pulse and a sticky flag.
// - Sits after the millisecond counter; drives alarm, terminal-count and display-event logic.

---
 rtl/comparador_multi.sv | 107 ++++++++++
 tb/tb_comparador_multi.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/comparador_multi.sv
// comparador_multi: compares one counter value against several independent
// thresholds. Each channel has its own compare mode, a persistence filter
// (HOLD consecutive true cycles), a rising-edge pulse and a sticky event flag.
module comparador_multi #(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 4,
  parameter int HOLD     = 1
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      EN,
  input  logic [WIDTH-1:0]          A,
  input  logic [CHANNELS*WIDTH-1:0] B,
  input  logic [2*CHANNELS-1:0]     MODE,
  input  logic [CHANNELS-1:0]       CLR_STICKY,
  output logic [CHANNELS-1:0]       MATCH,
  output logic [CHANNELS-1:0]       PULSE,
  output logic [CHANNELS-1:0]       STICKY,
  output logic                      ANY
);

  // Hold counter must be able to represent the value HOLD itself.
  localparam int            CW     = $clog2(HOLD + 1);
  localparam logic [CW-1:0] HOLD_V = CW'(HOLD);

  localparam logic [1:0] MODE_EQ = 2'b00;
  localparam logic [1:0] MODE_NE = 2'b01;
  localparam logic [1:0] MODE_GE = 2'b10;
  localparam logic [1:0] MODE_LE = 2'b11;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [WIDTH-1:0] b_c;
      logic [1:0]       mode_c;
      logic             raw_c;
      logic [CW-1:0]    cnt_reg;
      logic [CW-1:0]    cnt_next;
      logic             hit_next;
      logic             set_sticky;
      logic             match_reg;
      logic             pulse_reg;
      logic             sticky_reg;

      assign b_c    = B[gi*WIDTH +: WIDTH];
      assign mode_c = MODE[2*gi +: 2];

      // Unsigned compare of A against this channel's threshold in its mode.
      always_comb begin
        raw_c = 1'b0;
        case (mode_c)
          MODE_EQ: raw_c = (A == b_c);
          MODE_NE: raw_c = (A != b_c);
          MODE_GE: raw_c = (A >= b_c);
          MODE_LE: raw_c = (A <= b_c);
          default: raw_c = 1'b0;
        endcase
      end

      // Saturating persistence count; any false compare restarts the run.
      always_comb begin
        cnt_next = '0;
        if (raw_c) begin
          if (cnt_reg == HOLD_V) cnt_next = HOLD_V;
          else                   cnt_next = cnt_reg + CW'(1);
        end
      end

      assign hit_next   = (cnt_next == HOLD_V);
      // Rising edge of the filtered level; only meaningful while enabled.
      assign set_sticky = EN & hit_next & ~match_reg;

      // Count, level and pulse advance only when enabled; the pulse is
      // forced low while frozen so it never stretches across an EN gap.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          cnt_reg   <= '0;
          match_reg <= 1'b0;
          pulse_reg <= 1'b0;
        end else if (EN) begin
          cnt_reg   <= cnt_next;
          match_reg <= hit_next;
          pulse_reg <= hit_next & ~match_reg;
        end else begin
          pulse_reg <= 1'b0;
        end
      end

      // Sticky flag: a new event beats a clear arriving on the same edge;
      // the clear works regardless of EN.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          sticky_reg <= 1'b0;
        end else begin
          sticky_reg <= set_sticky | (sticky_reg & ~CLR_STICKY[gi]);
        end
      end

      assign MATCH[gi]  = match_reg;
      assign PULSE[gi]  = pulse_reg;
      assign STICKY[gi] = sticky_reg;
    end
  endgenerate

  assign ANY = |MATCH;

endmodule

// File: tb/tb_comparador_multi.sv
// Directed bench for comparador_multi: one instance with HOLD=1 and one with
// HOLD=3 share the same stimulus; expected values are hand-derived constants.
module tb_comparador_multi;

  logic        CLK;
  logic        RST_N;
  logic        EN;
  logic [4:0]  A;
  logic [19:0] B;
  logic [7:0]  MODE;
  logic [3:0]  CLR_STICKY;

  logic [3:0]  match1, pulse1, sticky1;
  logic [3:0]  match3, pulse3, sticky3;
  logic        any1, any3;

  int n_checks = 0;
  int n_pass   = 0;

  comparador_multi #(.WIDTH(5), .CHANNELS(4), .HOLD(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .A(A), .B(B), .MODE(MODE),
    .CLR_STICKY(CLR_STICKY), .MATCH(match1), .PULSE(pulse1),
    .STICKY(sticky1), .ANY(any1)
  );

  comparador_multi #(.WIDTH(5), .CHANNELS(4), .HOLD(3)) dut3 (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .A(A), .B(B), .MODE(MODE),
    .CLR_STICKY(CLR_STICKY), .MATCH(match3), .PULSE(pulse3),
    .STICKY(sticky3), .ANY(any3)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %s: got %b expected %b ok", tag, got, exp);
    end else begin
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // ch0 EQ 5, ch1 GE 10, ch2 LE 0, ch3 NE 7
    B          = {5'd7, 5'd0, 5'd10, 5'd5};
    MODE       = {2'b01, 2'b11, 2'b10, 2'b00};
    A          = 5'd0;
    EN         = 1'b0;
    CLR_STICKY = 4'b0000;
    RST_N      = 1'b1;
    #2 RST_N   = 1'b0;
    repeat (2) tick();

    check("rst_match1",  match1,  4'b0000);
    check("rst_pulse1",  pulse1,  4'b0000);
    check("rst_sticky1", sticky1, 4'b0000);
    check("rst_any1",    4'(any1), 4'd0);
    check("rst_match3",  match3,  4'b0000);
    check("rst_pulse3",  pulse3,  4'b0000);
    check("rst_sticky3", sticky3, 4'b0000);
    check("rst_any3",    4'(any3), 4'd0);

    RST_N = 1'b1;
    EN    = 1'b1;

    // HOLD=1, ch0 EQ 5: A steps 4,5,6
    A = 5'd4; tick();
    check("eq_a4_match0", 4'(match1[0]), 4'd0);
    A = 5'd5; tick();
    check("eq_a5_match0",  4'(match1[0]),  4'd1);
    check("eq_a5_pulse0",  4'(pulse1[0]),  4'd1);
    check("eq_a5_sticky0", 4'(sticky1[0]), 4'd1);
    A = 5'd6; tick();
    check("eq_a6_match0",  4'(match1[0]),  4'd0);
    check("eq_a6_pulse0",  4'(pulse1[0]),  4'd0);
    check("eq_a6_sticky0", 4'(sticky1[0]), 4'd1);

    // HOLD=3, ch1 GE 10: short run of 2 never asserts
    A = 5'd10; tick();
    check("ge_short1_match1", 4'(match3[1]), 4'd0);
    tick();
    check("ge_short2_match1", 4'(match3[1]), 4'd0);
    A = 5'd3; tick();
    check("ge_break_match1", 4'(match3[1]), 4'd0);
    A = 5'd12; tick();
    check("ge_run1_match1", 4'(match3[1]), 4'd0);
    tick();
    check("ge_run2_match1", 4'(match3[1]), 4'd0);
    tick();
    check("ge_run3_match1", 4'(match3[1]), 4'd1);
    check("ge_run3_pulse1", 4'(pulse3[1]), 4'd1);
    tick();
    check("ge_run4_match1", 4'(match3[1]), 4'd1);
    check("ge_run4_pulse1", 4'(pulse3[1]), 4'd0);

    // ch2 LE 0 and ch3 NE 7 together
    A = 5'd0; tick();
    check("a0_match_all", match1, 4'b1100);
    check("a0_pulse_all", pulse1, 4'b0100);
    check("a0_any",       4'(any1), 4'd1);
    check("a0_h3_fall1",  4'(match3[1]), 4'd0);
    A = 5'd7; tick();
    check("a7_match_all", match1, 4'b0000);
    check("a7_any",       4'(any1), 4'd0);

    // Sticky: set wins over clear on the same edge, clear alone works
    A = 5'd5; CLR_STICKY = 4'b0001; tick();
    check("stk_setclr_pulse0",  4'(pulse1[0]),  4'd1);
    check("stk_setclr_sticky0", 4'(sticky1[0]), 4'd1);
    CLR_STICKY = 4'b0000; A = 5'd6; tick();
    check("stk_hold_sticky0", 4'(sticky1[0]), 4'd1);
    CLR_STICKY = 4'b0001; tick();
    check("stk_clr_sticky", sticky1, 4'b1110);
    CLR_STICKY = 4'b0000;

    // EN freeze on HOLD=3 instance
    A = 5'd12; tick(); tick();
    check("en_pre2_match1", 4'(match3[1]), 4'd0);
    tick();
    check("en_pre3_match1", 4'(match3[1]), 4'd1);
    EN = 1'b0; A = 5'd3; CLR_STICKY = 4'b0010; tick();
    check("en_off_match1",  4'(match3[1]),  4'd1);
    check("en_off_pulse",   pulse3,         4'b0000);
    check("en_off_clr_stk", 4'(sticky3[1]), 4'd0);
    CLR_STICKY = 4'b0000; tick();
    check("en_off2_match1", 4'(match3[1]), 4'd1);
    EN = 1'b1; tick();
    check("en_on_match1", 4'(match3[1]), 4'd0);

    // Async reset mid-cycle with ch1 count at 2
    A = 5'd12; tick(); tick();
    check("rst2_pre_match1", 4'(match3[1]), 4'd0);
    #1 RST_N = 1'b0;
    #1;
    check("rst2_match",  match3,  4'b0000);
    check("rst2_pulse",  pulse3,  4'b0000);
    check("rst2_sticky", sticky3, 4'b0000);
    check("rst2_any",    4'(any3), 4'd0);
    #1 RST_N = 1'b1;
    tick();
    check("rst2_run1_match1", 4'(match3[1]), 4'd0);
    tick();
    check("rst2_run2_match1", 4'(match3[1]), 4'd0);
    tick();
    check("rst2_run3_match1", 4'(match3[1]), 4'd1);
    check("rst2_run3_pulse1", 4'(pulse3[1]), 4'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
